// File: rtl/adder_seg_display_if.sv
// ---------------------------------------------------------------------------
// adder_seg_display_if
//   Groups the adder-result capture bus and the seven-segment display outputs
//   of adder_seg_display.
//
//   Signals:
//     a, b   [3:0]  operands from the adder inputs
//     sum    [3:0]  adder sum
//     cout          adder carry out
//     load          capture strobe (pulse or level)
//     an     [3:0]  digit enables, active-low, an[0] = digit0
//     seg    [6:0]  segments, active-low, {g,f,e,d,c,b,a}
//     dp            decimal point, active-low
//
//   Modports:
//     master : drives the capture bus, observes the display
//     slave  : the display block itself
// ---------------------------------------------------------------------------
interface adder_seg_display_if;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] sum;
    logic       cout;
    logic       load;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (output a, b, sum, cout, load, input  an, seg, dp);
    modport slave  (input  a, b, sum, cout, load, output an, seg, dp);
endinterface

// File: rtl/adder_seg_display.sv
// ---------------------------------------------------------------------------
// adder_seg_display
//   Output stage behind the 4-bit adder. Captures a, b, sum and cout on load
//   and time-multiplexes them onto a 4-digit common-anode seven-segment
//   display: digit3 = a, digit2 = b, digit1 = cout, digit0 = sum. The decimal
//   point of digit0 marks a carry out. All display outputs are active-low.
//
//   Parameters:
//     REFRESH_DIV  clk cycles per digit slot (>= 2)
//     BLINK_SCANS  full 4-digit scans per blink half-period (OVF_BLINK_EN)
//
//   Ports:
//     clk  in   system clock, rising edge
//     rst  in   synchronous, active-high reset; also blanks the outputs
//               combinationally while asserted
//     bus  slave modport of adder_seg_display_if (capture bus + display)
//
//   Build option:
//     OVF_BLINK_EN  when defined, digits 0 and 1 blink while the captured
//                   carry is set; otherwise the display is steady.
// ---------------------------------------------------------------------------
module adder_seg_display #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_SCANS = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    adder_seg_display_if.slave    bus
);

    if (REFRESH_DIV < 2) begin : g_bad_div
        $error("adder_seg_display: REFRESH_DIV must be at least 2");
    end
    if (BLINK_SCANS < 1) begin : g_bad_blink
        $error("adder_seg_display: BLINK_SCANS must be at least 1");
    end

    localparam int             P_W    = $clog2(REFRESH_DIV);
    localparam logic [P_W-1:0] P_LAST = P_W'(REFRESH_DIV - 1);

    logic [P_W-1:0] r_p;
    logic [1:0]     r_idx;
    logic [3:0]     r_cap_a;
    logic [3:0]     r_cap_b;
    logic [3:0]     r_cap_s;
    logic           r_cap_c;

    logic           w_slot_end;
    logic           w_scan_end;
    logic           w_blank;
    logic [3:0]     w_digit;
    logic [6:0]     w_seg;

    // Last cycle of a slot: the digit goes dark here so the next digit's
    // segment pattern never ghosts onto the previous anode.
    assign w_slot_end = (r_p == P_LAST);
    assign w_scan_end = w_slot_end && (r_idx == 2'd3);

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent
    // simulation that no longer matches the synthesized flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p     <= '0;
            r_idx   <= 2'd0;
            r_cap_a <= 4'd0;
            r_cap_b <= 4'd0;
            r_cap_s <= 4'd0;
            r_cap_c <= 1'b0;
        end else begin
            r_p <= w_slot_end ? '0 : r_p + 1'b1;
            if (w_slot_end) begin
                r_idx <= r_idx + 2'd1;  // 3 -> 0 wraps naturally
            end
            if (bus.load) begin
                r_cap_a <= bus.a;
                r_cap_b <= bus.b;
                r_cap_s <= bus.sum;
                r_cap_c <= bus.cout;
            end
        end
    end

`ifdef OVF_BLINK_EN
    localparam int SC_W = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

    logic [SC_W-1:0] r_scan_cnt;
    logic            r_blink;

    // A new capture restarts the blink phase so a fresh result is always
    // shown lit first.
    always_ff @(posedge clk) begin
        if (rst || bus.load) begin
            r_scan_cnt <= '0;
            r_blink    <= 1'b0;
        end else if (w_scan_end) begin
            if (r_scan_cnt == SC_W'(BLINK_SCANS - 1)) begin
                r_scan_cnt <= '0;
                r_blink    <= ~r_blink;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
        end
    end

    // Blank the sum and carry digits (idx 0 and 1) during the off phase.
    assign w_blank = r_cap_c & r_blink & ~r_idx[1];
`else
    assign w_blank = 1'b0;
`endif

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0:    return 7'h40;
            4'h1:    return 7'h79;
            4'h2:    return 7'h24;
            4'h3:    return 7'h30;
            4'h4:    return 7'h19;
            4'h5:    return 7'h12;
            4'h6:    return 7'h02;
            4'h7:    return 7'h78;
            4'h8:    return 7'h00;
            4'h9:    return 7'h10;
            4'hA:    return 7'h08;
            4'hB:    return 7'h03;
            4'hC:    return 7'h46;
            4'hD:    return 7'h21;
            4'hE:    return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    // NOTE: every signal written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_digit = r_cap_a;
        case (r_idx)
            2'd0:    w_digit = r_cap_s;
            2'd1:    w_digit = {3'b000, r_cap_c};
            2'd2:    w_digit = r_cap_b;
            default: w_digit = r_cap_a;
        endcase
    end

    assign w_seg = hex_to_seg(w_digit);

    // Outputs depend only on registers and rst; the capture inputs never
    // reach the display combinationally.
    always_comb begin
        bus.an  = 4'b1111;
        bus.seg = 7'h7F;
        bus.dp  = 1'b1;
        if (!rst) begin
            if (!w_slot_end) begin
                bus.an = ~(4'b0001 << r_idx);
            end
            if (!w_blank) begin
                bus.seg = w_seg;
                bus.dp  = ~((r_idx == 2'd0) && !w_slot_end && r_cap_c);
            end
        end
    end

endmodule
